i2c_slave_regmap_ctrl: RTL and testbench
========================================

// Module: i2c_slave_regmap_ctrl
// PURPOSE
// Register-map sequencer sitting between the I2C slave byte engine and local logic.
// After each address-matched I2C transaction it interprets the byte stream as pointer and data, then auto-increments the pointer.
// Implements a REG_COUNT x 8 register file and arbitrates its single write port between the I2C side and a local host port.
// PARAMETERS
// REG_COUNT  16  number of 8-bit registers (2..256)
// ADDR_W     4   pointer/host address width, >= clog2(REG_COUNT)
// PORTS
// clk          in   1       system clock, all logic on posedge
// reset        in   1       reset, synchronous, active-low
// i2c_start    in   1       1-cycle pulse: START/RESTART + own address matched
// i2c_rw       in   1       R/W bit of matched address, valid with i2c_start (1=read)
// i2c_stop     in   1       1-cycle pulse: STOP detected
// rx_valid     in   1       1-cycle pulse: data byte received (address byte excluded)
// rx_byte      in   8       received byte, valid with rx_valid
// tx_load      in   1       1-cycle pulse: slave consumed tx_byte, wants next
// tx_byte      out  8       byte the slave shifts out on next read
// host_req     in   1       host register access request, held until host_gnt
// host_we      in   1       1=write, 0=read
// host_addr    in   ADDR_W  host register index
// host_wdata   in   8       host write data
// host_gnt     out  1       1-cycle pulse: host access performed this cycle
// host_rdata   out  8       host read data, valid the cycle after host_gnt
// busy         out  1       high while FSM not in IDLE
// range_err    out  1       sticky: I2C accessed index >= REG_COUNT; cleared by reset
// BEHAVIOUR
// - Reset (reset==0 at posedge): FSM=IDLE, ptr=0, all regs=8'h00, tx_byte=8'h00,
//   host_gnt=0, host_rdata=8'h00, busy=0, range_err=0. Reset mid-transaction aborts it.
// - States: IDLE, PTR, WRITE, READ.
//   IDLE/any --i2c_start & !i2c_rw--> PTR; IDLE/any --i2c_start & i2c_rw--> READ.
//   PTR --rx_valid--> WRITE, ptr<=rx_byte[ADDR_W-1:0], no reg write.
//   WRITE --rx_valid--> reg[ptr]<=rx_byte, ptr<=ptr+1 (stay WRITE).
//   READ  --tx_load--> ptr<=ptr+1 (stay READ).
//   any --i2c_stop--> IDLE; ptr retained across transactions (repeated-start read-back).
// - tx_byte: registered, = reg[ptr] (8'hFF if ptr>=REG_COUNT); updated every cycle so
//   one cycle after entry to READ or after a tx_load the next byte is ready.
// - Pointer wraps REG_COUNT-1 -> 0; ADDR_W-bit ptr loaded >= REG_COUNT: writes dropped,
//   reads return 8'hFF, range_err set.
// - Simultaneous events: i2c_start beats rx_valid/tx_load (byte ignored); i2c_stop with
//   rx_valid: byte processed first, then IDLE. i2c_start while busy = restart.
// - Arbitration: I2C register write (WRITE & rx_valid) has priority; host_gnt=0 that
//   cycle, host retries next cycle. Otherwise host_req -> host_gnt same cycle.
//   Host write and I2C read of same reg: tx_byte reflects new value next cycle.
// - host_addr >= REG_COUNT: granted, write dropped, host_rdata=8'hFF, range_err untouched.
// CONFIGURATION
// I2C_REGMAP_AUTOINC_EN defined: ptr increments after each WRITE byte / tx_load as above.
// Not defined: ptr never increments; all WRITE bytes hit the same reg, reads repeat it.
// STRUCTURE
// - FSM state codes, REGMAP_ERR_BYTE (8'hFF) in shared I2C.vh header alongside
//   existing I2C state constants.
// - One sub-module: i2c_regmap_file (REG_COUNT x 8, 1 write port, 2 comb read ports).
// TESTING
// 1. Write: start(rw=0), rx 8'h03,8'hA5,8'h5A, stop -> reg3=A5, reg4=5A, ptr=5, busy low.
// 2. Read-back: start(rw=0), rx 8'h03, restart(rw=1), 2x tx_load -> tx_byte A5,5A,00.
// 3. Wrap: ptr=REG_COUNT-1, write 8'h11,8'h22 -> reg15=11, reg0=22, range_err=0.
// 4. Collision: host_req we=1 addr=2 during I2C rx_valid -> host_gnt=0 that cycle,
//    =1 next; reg2=host_wdata, I2C byte also written.
// 5. Range: REG_COUNT=12, pointer 8'h0E then data 8'h77 -> no write, range_err=1, read FF.
// 6. Reset mid-WRITE after 1 byte -> all regs 00, IDLE, ptr 0; macro off: 3 writes hit ptr.

Source files
------------

// File: rtl/i2c_slave_regmap_ctrl_pkg.sv
// Shared definitions for the I2C slave register-map sequencer: FSM state codes
// and the byte returned for out-of-range register indices.
package i2c_slave_regmap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PTR   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } regmap_state_e;

  localparam logic [7:0] REGMAP_ERR_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_regmap_file.sv
// REG_COUNT x 8 register file: one synchronous write port, two combinational
// read ports. Reads of an index beyond REG_COUNT return zero; callers substitute.
module i2c_regmap_file #(
  parameter int REG_COUNT = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [7:0]        rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [7:0]        rdata_b
);

  logic [7:0] mem [REG_COUNT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (int'(raddr_a) < REG_COUNT) ? mem[raddr_a] : 8'h00;
  assign rdata_b = (int'(raddr_b) < REG_COUNT) ? mem[raddr_b] : 8'h00;

endmodule

// File: rtl/i2c_slave_regmap_ctrl.sv
// I2C slave register-map sequencer with host port arbitration.
// Define I2C_REGMAP_AUTOINC_EN to auto-increment the pointer after each byte.
module i2c_slave_regmap_ctrl
  import i2c_slave_regmap_ctrl_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_start,
  input  logic              i2c_rw,
  input  logic              i2c_stop,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_load,
  output logic [7:0]        tx_byte,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              range_err
);

`ifdef I2C_REGMAP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < REG_COUNT;
  endfunction

  // Wraps at the end of the populated map, not at 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if (int'(p) == REG_COUNT - 1) return '0;
    return p + ADDR_W'(1);
  endfunction

  regmap_state_e     state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_after;
  logic              i2c_byte_wr;
  logic              host_wr;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_waddr;
  logic [7:0]        reg_wdata;
  logic [7:0]        ptr_rdata;
  logic [7:0]        host_rd;

  assign ptr_after   = AUTOINC ? ptr_inc(ptr) : ptr;
  // A data byte in WRITE owns the write port even when its index is dropped.
  assign i2c_byte_wr = (state == ST_WRITE) && rx_valid && !i2c_start;
  assign host_gnt    = reset && host_req && !i2c_byte_wr;
  assign host_wr     = host_gnt && host_we && in_range(host_addr);
  assign reg_we      = (i2c_byte_wr && in_range(ptr)) || host_wr;
  assign reg_waddr   = i2c_byte_wr ? ptr : host_addr;
  assign reg_wdata   = i2c_byte_wr ? rx_byte : host_wdata;
  assign busy        = (state != ST_IDLE);

  i2c_regmap_file #(
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W)
  ) u_file (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_we),
    .waddr   (reg_waddr),
    .wdata   (reg_wdata),
    .raddr_a (ptr),
    .rdata_a (ptr_rdata),
    .raddr_b (host_addr),
    .rdata_b (host_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      range_err <= 1'b0;
    end else if (i2c_start) begin
      state <= i2c_rw ? ST_READ : ST_PTR;
    end else begin
      case (state)
        ST_PTR: if (rx_valid) begin
          ptr   <= rx_byte[ADDR_W-1:0];
          state <= ST_WRITE;
          if (!in_range(rx_byte[ADDR_W-1:0])) range_err <= 1'b1;
        end
        ST_WRITE: if (rx_valid) ptr <= ptr_after;
        ST_READ:  if (tx_load)  ptr <= ptr_after;
        default: ;
      endcase
      if (i2c_stop) state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_byte    <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      tx_byte <= in_range(ptr) ? ptr_rdata : REGMAP_ERR_BYTE;
      if (host_gnt && !host_we)
        host_rdata <= in_range(host_addr) ? host_rd : REGMAP_ERR_BYTE;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regmap_ctrl.sv
// Self-checking bench for i2c_slave_regmap_ctrl: directed transactions then
// random traffic, each cycle compared against a transaction-level register-map model.
module tb_i2c_slave_regmap_ctrl;

  localparam int RC = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i2c_start = 1'b0, i2c_rw = 1'b0, i2c_stop = 1'b0;
  logic          rx_valid = 1'b0, tx_load = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [7:0]    tx_byte;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = 8'h00;
  logic          host_gnt;
  logic [7:0]    host_rdata;
  logic          busy, range_err;

  always #5 clk = ~clk;

  i2c_slave_regmap_ctrl #(.REG_COUNT(RC), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_stop(i2c_stop),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_load(tx_load), .tx_byte(tx_byte),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .busy(busy), .range_err(range_err)
  );

`ifdef I2C_REGMAP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Model: transaction phase 0=idle, 1=awaiting pointer byte, 2=writing, 3=reading.
  int m_regs [16];
  int m_ptr   = 0;
  int m_phase = 0;
  bit m_rerr  = 1'b0;
  int m_tx    = 0;
  int m_rdata = 0;

  function automatic bit valid_idx(input int i);
    return i < RC;
  endfunction

  function automatic int next_idx(input int p);
    return (p == RC - 1) ? 0 : (p + 1) % (1 << AW);
  endfunction

  function automatic int read_val(input int i);
    return valid_idx(i) ? m_regs[i] : 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit st, input bit rw, input bit sp, input bit rv,
                      input logic [7:0] rb, input bit tl, input bit hr, input bit hw,
                      input logic [AW-1:0] ha, input logic [7:0] hwd);
    bit exp_gnt, i2c_data;
    i2c_start = st; i2c_rw = rw; i2c_stop = sp; rx_valid = rv; rx_byte = rb;
    tx_load = tl; host_req = hr; host_we = hw; host_addr = ha; host_wdata = hwd;
    #1;
    i2c_data = (m_phase == 2) && rv && !st;
    exp_gnt  = reset && hr && !i2c_data;
    chk("host_gnt", {7'b0, host_gnt}, {7'b0, exp_gnt});
    @(posedge clk);
    if (!reset) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_ptr = 0; m_phase = 0; m_rerr = 1'b0; m_tx = 0; m_rdata = 0;
    end else begin
      m_tx = read_val(m_ptr);
      if (exp_gnt && !hw) m_rdata = read_val(int'(ha));
      if (exp_gnt && hw && valid_idx(int'(ha))) m_regs[int'(ha)] = int'(hwd);
      if (st) begin
        m_phase = rw ? 3 : 1;
      end else begin
        if (m_phase == 1 && rv) begin
          m_ptr = int'(rb) % (1 << AW);
          if (!valid_idx(m_ptr)) m_rerr = 1'b1;
          m_phase = 2;
        end else if (m_phase == 2 && rv) begin
          if (valid_idx(m_ptr)) m_regs[m_ptr] = int'(rb);
          if (AUTOINC) m_ptr = next_idx(m_ptr);
        end else if (m_phase == 3 && tl) begin
          if (AUTOINC) m_ptr = next_idx(m_ptr);
        end
        if (sp) m_phase = 0;
      end
    end
    #1;
    chk("busy", {7'b0, busy}, {7'b0, m_phase != 0});
    chk("range_err", {7'b0, range_err}, {7'b0, m_rerr});
    chk("tx_byte", tx_byte, 8'(m_tx));
    chk("host_rdata", host_rdata, 8'(m_rdata));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00, 0, 0, 0, '0, 8'h00);
  endtask
  task automatic start(input bit rw);
    step(1, rw, 0, 0, 8'h00, 0, 0, 0, '0, 8'h00);
  endtask
  task automatic stop();
    step(0, 0, 1, 0, 8'h00, 0, 0, 0, '0, 8'h00);
  endtask
  task automatic rx(input logic [7:0] b);
    step(0, 0, 0, 1, b, 0, 0, 0, '0, 8'h00);
  endtask
  task automatic txl();
    step(0, 0, 0, 0, 8'h00, 1, 0, 0, '0, 8'h00);
  endtask
  task automatic hread(input int a);
    step(0, 0, 0, 0, 8'h00, 0, 1, 0, AW'(a), 8'h00);
    idle();
  endtask
  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) idle();
    reset = 1'b1;
  endtask

  initial begin
    do_reset(2);
    idle();
    // Basic write with pointer, then host read-back.
    start(0); rx(8'h03); rx(8'hA5); rx(8'h5A); stop(); idle();
    hread(3); hread(4);
    // Pointer write then repeated-start read.
    start(0); rx(8'h03); start(1); idle(); idle();
    txl(); idle(); idle(); txl(); idle(); idle(); stop();
    // Pointer at last register: wrap.
    start(0); rx(8'(RC - 1)); rx(8'h11); rx(8'h22); stop(); idle();
    hread(RC - 1); hread(0);
    // Host write collides with I2C data byte, retries next cycle.
    start(0); rx(8'h02);
    step(0, 0, 0, 1, 8'h99, 0, 1, 1, AW'(2), 8'hC3);
    step(0, 0, 0, 0, 8'h00, 0, 1, 1, AW'(2), 8'hC3);
    stop(); hread(2); hread(3);
    // Out-of-range pointer: write dropped, read returns FF.
    start(0); rx(8'h0E); rx(8'h77); stop();
    start(1); idle(); idle(); txl(); idle(); idle(); stop(); idle();
    // Host access beyond the map.
    hread(13);
    step(0, 0, 0, 0, 8'h00, 0, 1, 1, AW'(13), 8'h5C); idle(); hread(13);
    // Start beats a simultaneous data byte.
    start(0); rx(8'h06); step(1, 1, 0, 1, 8'hEE, 0, 0, 0, '0, 8'h00); idle(); stop();
    hread(6);
    // Reset in the middle of a write transaction.
    start(0); rx(8'h05); rx(8'h44);
    do_reset(1); idle();
    hread(5); hread(3);
    // Repeated writes follow the pointer policy.
    start(0); rx(8'h07); rx(8'h01); rx(8'h02); rx(8'h03); stop(); idle();
    hread(7); hread(8); hread(9);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit st, sp;
      st = ($urandom_range(0, 11) == 0);
      sp = !st && ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 149) != 0);
      step(st, 1'($urandom), sp, ($urandom_range(0, 2) == 0), 8'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
           AW'($urandom), 8'($urandom));
    end
    reset = 1'b1;
    stop(); idle();
    for (int a = 0; a < 16; a++) hread(a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
